// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite types, defaults and byte-lane helper
package ahb_pkg;

    localparam int AHB_ADDR_WIDTH = 32;
    localparam int AHB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } sram_state_e;

    // Little-endian lane mask for a transfer of 2^hsize bytes at addr_lsbs, clipped to nbytes lanes.
    function automatic logic [7:0] ahb_byte_en(input logic [2:0] hsize,
                                               input logic [2:0] addr_lsbs,
                                               input int nbytes);
        logic [7:0] base;
        logic [7:0] shifted;
        logic [7:0] mask;
        case (hsize)
            3'd0:    base = 8'h01;
            3'd1:    base = 8'h03;
            3'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        shifted = base << addr_lsbs;
        for (int i = 0; i < 8; i++) begin
            mask[i] = (i < nbytes);
        end
        return shifted & mask;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// rtl/ahb_sram_array.sv - flop array with byte-enabled synchronous write and combinational read
module ahb_sram_array #(
    parameter int  DATA_WIDTH = 32,
    parameter int  MEM_DEPTH  = 1024,
    localparam int NBYTES     = DATA_WIDTH / 8,
    localparam int IDX_BITS   = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [NBYTES-1:0]     be,
    input  logic [IDX_BITS-1:0]   addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// rtl/ahb_lite_sram_slave.sv - AHB-Lite slave fronting a word-addressed SRAM with wait states and ERROR responses
module ahb_lite_sram_slave
    import ahb_pkg::*;
#(
    parameter int                  ADDR_WIDTH  = AHB_ADDR_WIDTH,
    parameter int                  DATA_WIDTH  = AHB_DATA_WIDTH,
    parameter int                  MEM_DEPTH   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int                  WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int NBYTES    = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(NBYTES);
    localparam int IDX_BITS  = $clog2(MEM_DEPTH);
    localparam int OFF_BITS  = IDX_BITS + LANE_BITS;

    sram_state_e           state, state_nxt;
    logic [3:0]            wait_cnt, wait_cnt_nxt;
    logic                  ready, resp;
    logic                  dp_valid, dp_write;
    logic [OFF_BITS-1:0]   dp_addr;
    logic [2:0]            dp_size;
    logic                  accept, in_range, size_ok, aligned, legal, we;
    logic [LANE_BITS-1:0]  align_mask;
    logic [7:0]            be_full;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused;

    assign accept = HSEL & HREADY & HTRANS[1];

    // BASE_ADDR is aligned to the array size, so a range check is a compare of the upper bits.
    assign in_range   = HADDR[ADDR_WIDTH-1:OFF_BITS] == BASE_ADDR[ADDR_WIDTH-1:OFF_BITS];
    assign size_ok    = 32'(HSIZE) <= 32'(LANE_BITS);
    assign align_mask = LANE_BITS'((32'd1 << HSIZE) - 32'd1);
    assign aligned    = (HADDR[LANE_BITS-1:0] & align_mask) == '0;
    assign legal      = in_range & size_ok & aligned;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        ready        = 1'b1;
        resp         = HRESP_OKAY;
        unique case (state)
            ST_WAIT: begin
                ready        = 1'b0;
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ERR1: begin
                ready     = 1'b0;
                resp      = HRESP_ERROR;
                state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                resp      = HRESP_ERROR;
                state_nxt = ST_IDLE;
            end
            default: ;
        endcase
        // A new address phase is only taken in a cycle where this slave is ready.
        if (ready && accept) begin
            if (!legal) begin
                state_nxt = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_nxt    = ST_WAIT;
                wait_cnt_nxt = 4'(WAIT_STATES);
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            dp_size  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (ready) begin
                dp_valid <= accept & legal;
                if (accept) begin
                    dp_write <= HWRITE;
                    dp_addr  <= HADDR[OFF_BITS-1:0];
                    dp_size  <= HSIZE;
                end
            end
        end
    end

    assign we      = dp_valid & dp_write & ready;
    assign be_full = ahb_byte_en(dp_size, 3'(dp_addr[LANE_BITS-1:0]), NBYTES);

    ahb_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .clk   (HCLK),
        .we    (we),
        .be    (be_full[NBYTES-1:0]),
        .addr  (dp_addr[OFF_BITS-1:LANE_BITS]),
        .wdata (HWDATA),
        .rdata (rd_word)
    );

    assign HREADYOUT = ready;
    assign HRESP     = resp;
    assign HRDATA    = (dp_valid && !dp_write) ? rd_word : '0;
    assign unused    = ^{HBURST, HTRANS[0], be_full};

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb/tb_ahb_lite_sram_slave.sv - table-driven scoreboard bench for ahb_lite_sram_slave
module tb_ahb_lite_sram_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  hsel = '0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [2:0]  hburst = '0;
    logic [31:0] hwdata = '0;
    logic [2:0]  hreadyout;
    logic [2:0]  hresp;
    logic [31:0] hrdata [3];

    always #5 clk = ~clk;

    // Instance 0: no wait states, 1: three, 2: five.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_lite_sram_slave #(
            .WAIT_STATES (g == 0 ? 0 : (g == 1 ? 3 : 5))
        ) u_dut (
            .HCLK      (clk),
            .HRESETn   (rst_n),
            .HSEL      (hsel[g]),
            .HADDR     (haddr),
            .HTRANS    (htrans),
            .HWRITE    (hwrite),
            .HSIZE     (hsize),
            .HBURST    (hburst),
            .HWDATA    (hwdata),
            .HREADY    (hreadyout[g]),
            .HREADYOUT (hreadyout[g]),
            .HRESP     (hresp[g]),
            .HRDATA    (hrdata[g])
        );
    end

    typedef struct {
        int          k;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        int          k;
        logic        err;
        logic [31:0] rdata;
        int          stalls;
    } exp_t;

    vec_t        tbl [$];
    exp_t        sb [$];
    int          stall_cnt = 0;
    logic [31:0] pend_wdata = '0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 5);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired, got no completion, want completion", name);
    endtask

    // One cycle: present the current data-phase write data, then score the outstanding transfer.
    task automatic tick();
        @(negedge clk);
        hwdata = pend_wdata;
        if (sb.size() > 0) begin
            int k;
            k = sb[0].k;
            if (hreadyout[k]) begin
                exp_t e;
                e = sb.pop_front();
                check("stall_count", stall_cnt, e.stalls);
                check("hresp", 32'(hresp[k]), 32'(e.err));
                check("hrdata", hrdata[k], e.rdata);
                stall_cnt = 0;
            end else begin
                stall_cnt++;
                check("stall_hresp", 32'(hresp[k]), 32'(sb[0].err));
                check("stall_hrdata", hrdata[k], sb[0].rdata);
            end
        end
    endtask

    // Address phase is held until the slave is ready, then the expectation is queued.
    task automatic issue(input vec_t v);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        while (!done) begin
            tick();
            hsel      = '0;
            hsel[v.k] = 1'b1;
            htrans    = 2'b10;
            hwrite    = v.wr;
            haddr     = v.addr;
            hsize     = v.size;
            if (hreadyout[v.k]) begin
                sb.push_back('{k: v.k, err: v.err, rdata: v.rdata,
                               stalls: (v.err ? 1 : ws_of(v.k))});
                pend_wdata = v.wdata;
                done = 1;
            end else if (++n > 40) begin
                timeout("issue");
                done = 1;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 60) begin
            tick();
            hsel   = '0;
            htrans = 2'b00;
            n++;
        end
        if (sb.size() > 0) begin
            timeout("drain");
            sb.delete();
        end
    endtask

    initial begin
        int last_k;

        // k, wr, addr, size, wdata, err, expected rdata
        tbl.push_back('{0, 1'b1, 32'h10,   3'd2, 32'hDEADBEEF, 1'b0, 32'h0});
        tbl.push_back('{0, 1'b0, 32'h10,   3'd2, 32'h0,        1'b0, 32'hDEADBEEF});
        tbl.push_back('{0, 1'b1, 32'h0,    3'd2, 32'h11223344, 1'b0, 32'h0});
        tbl.push_back('{0, 1'b1, 32'h2,    3'd0, 32'h00AA0000, 1'b0, 32'h0});
        tbl.push_back('{0, 1'b0, 32'h0,    3'd2, 32'h0,        1'b0, 32'h11AA3344});
        tbl.push_back('{0, 1'b1, 32'h4,    3'd2, 32'h55667788, 1'b0, 32'h0});
        tbl.push_back('{0, 1'b1, 32'h6,    3'd1, 32'hBEEF0000, 1'b0, 32'h0});
        tbl.push_back('{0, 1'b0, 32'h4,    3'd2, 32'h0,        1'b0, 32'hBEEF7788});
        tbl.push_back('{0, 1'b0, 32'h1000, 3'd2, 32'h0,        1'b1, 32'h0});
        tbl.push_back('{0, 1'b0, 32'h1,    3'd1, 32'h0,        1'b1, 32'h0});
        tbl.push_back('{0, 1'b0, 32'h0,    3'd3, 32'h0,        1'b1, 32'h0});
        tbl.push_back('{0, 1'b1, 32'h2,    3'd2, 32'hFFFFFFFF, 1'b1, 32'h0});
        tbl.push_back('{0, 1'b0, 32'h0,    3'd2, 32'h0,        1'b0, 32'h11AA3344});
        tbl.push_back('{1, 1'b1, 32'h8,    3'd2, 32'hCAFEF00D, 1'b0, 32'h0});
        tbl.push_back('{1, 1'b0, 32'h8,    3'd2, 32'h0,        1'b0, 32'hCAFEF00D});
        tbl.push_back('{1, 1'b1, 32'hB,    3'd0, 32'h5A000000, 1'b0, 32'h0});
        tbl.push_back('{1, 1'b0, 32'h8,    3'd2, 32'h0,        1'b0, 32'h5AFEF00D});
        tbl.push_back('{2, 1'b1, 32'h20,   3'd2, 32'h0BADF00D, 1'b0, 32'h0});

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_hreadyout", 32'(hreadyout[k]), 32'd1);
            check("reset_hresp", 32'(hresp[k]), 32'd0);
            check("reset_hrdata", hrdata[k], 32'h0);
        end
        rst_n = 1'b1;

        last_k = 0;
        foreach (tbl[i]) begin
            if (tbl[i].k != last_k) drain();
            issue(tbl[i]);
            last_k = tbl[i].k;
        end
        drain();

        // IDLE and BUSY while selected, then NONSEQ while deselected: none may write.
        pend_wdata = 32'hFFFFFFFF;
        tick();
        hsel = 3'b001; htrans = 2'b00; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
        tick();
        check("idle_hreadyout", 32'(hreadyout[0]), 32'd1);
        check("idle_hresp", 32'(hresp[0]), 32'd0);
        htrans = 2'b01;
        tick();
        check("busy_hreadyout", 32'(hreadyout[0]), 32'd1);
        check("busy_hresp", 32'(hresp[0]), 32'd0);
        hsel = 3'b000; htrans = 2'b10;
        tick();
        check("nosel_hreadyout", 32'(hreadyout[0]), 32'd1);
        check("nosel_hresp", 32'(hresp[0]), 32'd0);
        htrans = 2'b00;
        issue('{0, 1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 32'hDEADBEEF});
        drain();

        // Reset in the second stall cycle of a write must abandon it.
        tick();
        hsel = 3'b100; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h20; hsize = 3'd2;
        pend_wdata = 32'h12345678;
        tick();
        hsel = 3'b000; htrans = 2'b00;
        check("rst_stall1_hreadyout", 32'(hreadyout[2]), 32'd0);
        tick();
        check("rst_stall2_hreadyout", 32'(hreadyout[2]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_hreadyout", 32'(hreadyout[2]), 32'd1);
        check("rst_mid_hresp", 32'(hresp[2]), 32'd0);
        check("rst_mid_hrdata", hrdata[2], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue('{2, 1'b0, 32'h20, 3'd2, 32'h0, 1'b0, 32'h0BADF00D});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
